// File: rtl/segasys1_sprcoll_ram.sv
// Sprite collision table: queues renderer collision pulses into a 1024x1 RAM,
// keeps sticky summary/overflow flags and serves CPU reads and clear-writes.
module segasys1_sprcoll_ram #(
    parameter int FIFO_DEPTH   = 4,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic       VCLKx8,
    input  logic       RST_N,
    input  logic       sprcoll,
    input  logic [9:0] sprcoll_ad,
    input  logic [9:0] cpu_ad,
    input  logic       cpu_ram_cs,
    input  logic       cpu_sum_cs,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    output logic [7:0] cpu_dout,
    output logic       cpu_dout_vld,
    output logic       coll_any,
    output logic       ovf,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic [9:0]  clrCnt_q, clrCnt_d;
    logic        rdPrev_q, wrPrev_q;
    logic        evVld_q, evVld_d;
    logic        evWr_q, evWr_d;
    logic        evSum_q, evSum_d;
    logic [9:0]  evAd_q, evAd_d;
    logic [AW:0] wrPtr_q, wrPtr_d;
    logic [AW:0] rdPtr_q, rdPtr_d;
    logic [7:0]  dout_q, dout_d;
    logic        vld_q, vld_d;
    logic        collAny_q, collAny_d;
    logic        ovf_q, ovf_d;

    logic [9:0]  fifoMem_q [FIFO_DEPTH];
    logic        mem_q [1024];

    logic        rdLvl, wrLvl, rdEv, wrEv, running;
    logic        fifoEmpty, fifoFull, ramByCpu, pop, push, drop;
    logic        ramWe, ramWd, ramRdBit;
    logic [9:0]  ramWa, fifoHead;

    assign rdLvl     = (cpu_ram_cs | cpu_sum_cs) & cpu_rd;
    assign wrLvl     = (cpu_ram_cs | cpu_sum_cs) & cpu_wr;
    assign rdEv      = rdLvl & ~rdPrev_q;
    assign wrEv      = wrLvl & ~wrPrev_q;
    assign running   = (state_q == ST_RUN);
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                       (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign fifoHead  = fifoMem_q[rdPtr_q[AW-1:0]];
    assign ramRdBit  = mem_q[evAd_q];

    // A registered CPU table access owns the RAM port; queued events wait a cycle.
    assign ramByCpu  = evVld_q & ~evSum_q;
    assign pop       = running & ~fifoEmpty & ~ramByCpu;
    assign push      = running & sprcoll & (~fifoFull | pop);
    assign drop      = running & sprcoll & fifoFull & ~pop;

    always_comb begin
        state_d   = state_q;
        clrCnt_d  = clrCnt_q;
        evVld_d   = running & (rdEv | wrEv);
        evWr_d    = wrEv;
        evSum_d   = ~cpu_ram_cs;
        evAd_d    = cpu_ad;
        wrPtr_d   = push ? wrPtr_q + (AW+1)'(1) : wrPtr_q;
        rdPtr_d   = pop  ? rdPtr_q + (AW+1)'(1) : rdPtr_q;
        dout_d    = dout_q;
        vld_d     = 1'b0;
        collAny_d = collAny_q;
        ovf_d     = ovf_q;
        ramWe     = 1'b0;
        ramWa     = 10'd0;
        ramWd     = 1'b0;

        if (state_q == ST_CLEAR) begin
            clrCnt_d = clrCnt_q + 10'd1;
            ramWe    = 1'b1;
            ramWa    = clrCnt_q;
            if (clrCnt_q == 10'h3FF) begin
                state_d = ST_RUN;
            end
        end else if (ramByCpu && evWr_q) begin
            ramWe = 1'b1;
            ramWa = evAd_q;
        end else if (pop) begin
            ramWe = 1'b1;
            ramWa = fifoHead;
            ramWd = 1'b1;
        end

        if (evVld_q && !evWr_q) begin
            vld_d  = 1'b1;
            dout_d = evSum_q ? {6'b0, ovf_q, collAny_q} : {7'b0, ramRdBit};
        end

        // Clears are applied first so a coincident set overrides them.
        if (evVld_q && evWr_q && evSum_q) begin
            collAny_d = 1'b0;
            ovf_d     = 1'b0;
        end
        if (pop) begin
            collAny_d = 1'b1;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge VCLKx8 or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= CLR_ON_RESET ? ST_CLEAR : ST_RUN;
            clrCnt_q  <= 10'd0;
            rdPrev_q  <= 1'b0;
            wrPrev_q  <= 1'b0;
            evVld_q   <= 1'b0;
            evWr_q    <= 1'b0;
            evSum_q   <= 1'b0;
            evAd_q    <= 10'd0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            dout_q    <= 8'h00;
            vld_q     <= 1'b0;
            collAny_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clrCnt_q  <= clrCnt_d;
            rdPrev_q  <= rdLvl;
            wrPrev_q  <= wrLvl;
            evVld_q   <= evVld_d;
            evWr_q    <= evWr_d;
            evSum_q   <= evSum_d;
            evAd_q    <= evAd_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            collAny_q <= collAny_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage arrays carry no reset; the sweep is what initialises the table.
    always_ff @(posedge VCLKx8) begin
        if (push) begin
            fifoMem_q[wrPtr_q[AW-1:0]] <= sprcoll_ad;
        end
        if (ramWe) begin
            mem_q[ramWa] <= ramWd;
        end
    end

    assign cpu_dout     = dout_q;
    assign cpu_dout_vld = vld_q;
    assign coll_any     = collAny_q;
    assign ovf          = ovf_q;
    assign busy         = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_segasys1_sprcoll_ram.sv
// Directed bench for segasys1_sprcoll_ram: sweep, capture, CPU access,
// overflow, clear/set ordering and asynchronous reset.
module tb_segasys1_sprcoll_ram;

    logic       clk = 1'b0;
    logic       rstN;
    logic       sprcoll;
    logic [9:0] sprcollAd;
    logic [9:0] cpuAd;
    logic       cpuRamCs, cpuSumCs, cpuRd, cpuWr;
    logic [7:0] cpuDout;
    logic       cpuDoutVld, collAny, ovf, busy;

    int checks = 0;
    int errors = 0;
    int vldCount;

    segasys1_sprcoll_ram #(.FIFO_DEPTH(4), .CLR_ON_RESET(1'b1)) dut (
        .VCLKx8(clk), .RST_N(rstN), .sprcoll(sprcoll), .sprcoll_ad(sprcollAd),
        .cpu_ad(cpuAd), .cpu_ram_cs(cpuRamCs), .cpu_sum_cs(cpuSumCs),
        .cpu_rd(cpuRd), .cpu_wr(cpuWr), .cpu_dout(cpuDout),
        .cpu_dout_vld(cpuDoutVld), .coll_any(collAny), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ramCs, input logic sumCs, input logic rd, input logic wr,
                                 input logic [9:0] ad, input logic sp, input logic [9:0] spAd);
        cpuRamCs  = ramCs;
        cpuSumCs  = sumCs;
        cpuRd     = rd;
        cpuWr     = wr;
        cpuAd     = ad;
        sprcoll   = sp;
        sprcollAd = spAd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
    endtask

    task automatic cpuRead(input logic isRam, input logic [9:0] ad, input logic [7:0] exp, input string tag);
        applyStimulus(isRam, !isRam, 1'b1, 1'b0, ad, 1'b0, 10'd0);
        tick();
        checkOutput({tag, "_vld_early"}, 32'(cpuDoutVld), 32'd0);
        tick();
        checkOutput({tag, "_vld"}, 32'(cpuDoutVld), 32'd1);
        checkOutput({tag, "_dout"}, 32'(cpuDout), 32'(exp));
        idle();
        tick();
    endtask

    task automatic cpuWrite(input logic isRam, input logic [9:0] ad);
        applyStimulus(isRam, !isRam, 1'b0, 1'b1, ad, 1'b0, 10'd0);
        tick();
        idle();
        tick();
    endtask

    task automatic runSweep(input string tag);
        for (int i = 0; i < 1023; i++) tick();
        checkOutput({tag, "_busy_1023"}, 32'(busy), 32'd1);
        tick();
        checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_dout"}, 32'(cpuDout), 32'd0);
        checkOutput({tag, "_vld"}, 32'(cpuDoutVld), 32'd0);
        checkOutput({tag, "_coll"}, 32'(collAny), 32'd0);
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        rstN = 1'b0;
        idle();
        #23;
        checkResetOutputs("rst");
        tick();
        rstN = 1'b1;
        runSweep("sweep0");

        cpuRead(1'b1, 10'd0,    8'h00, "rd_0");
        cpuRead(1'b1, 10'd517,  8'h00, "rd_517");
        cpuRead(1'b1, 10'd1023, 8'h00, "rd_1023");

        // Push lands on the first edge, the pop sets coll_any on the next.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'h2A3);
        tick();
        idle();
        checkOutput("coll_after_push", 32'(collAny), 32'd0);
        tick();
        checkOutput("coll_after_pop", 32'(collAny), 32'd1);
        cpuRead(1'b1, 10'h2A3, 8'h01, "rd_2a3");
        cpuRead(1'b1, 10'h2A4, 8'h00, "rd_2a4");

        cpuWrite(1'b1, 10'h2A3);
        cpuRead(1'b1, 10'h2A3, 8'h00, "rd_2a3_clr");
        cpuWrite(1'b0, 10'h000);
        checkOutput("sumclr_coll", 32'(collAny), 32'd0);
        checkOutput("sumclr_ovf", 32'(ovf), 32'd0);
        cpuRead(1'b0, 10'h000, 8'h00, "sum_rd0");

        // Read level held for 8 cycles: one event only, renderer traffic keeps draining.
        vldCount = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h300, 1'b1, 10'h100 + 10'(i));
            tick();
            if (cpuDoutVld) vldCount++;
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpuDoutVld) vldCount++;
        end
        checkOutput("held_rd_vld_count", 32'(vldCount), 32'd1);
        checkOutput("held_rd_dout", 32'(cpuDout), 32'd0);
        checkOutput("held_rd_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 8; i++) cpuRead(1'b1, 10'h100 + 10'(i), 8'h01, "held_ev");

        // Read and write rising together: the write clears, no read data appears.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 10'h100, 1'b0, 10'd0);
        tick();
        tick();
        checkOutput("rdwr_vld", 32'(cpuDoutVld), 32'd0);
        idle();
        tick();
        cpuRead(1'b1, 10'h100, 8'h00, "rdwr_clr");

        // Alternating rd/wr edges keep the RAM port busy every cycle so the FIFO fills.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, (i % 2) == 0, (i % 2) == 1, 10'h3FF, 1'b1, 10'h200 + 10'(i));
            tick();
            checkOutput($sformatf("ovf_ev%0d", i), 32'(ovf), (i >= 4) ? 32'd1 : 32'd0);
        end
        idle();
        for (int i = 0; i < 8; i++) tick();
        for (int i = 0; i < 4; i++) cpuRead(1'b1, 10'h200 + 10'(i), 8'h01, "ovf_kept");
        cpuRead(1'b1, 10'h204, 8'h00, "ovf_drop4");
        cpuRead(1'b1, 10'h205, 8'h00, "ovf_drop5");
        cpuRead(1'b0, 10'h000, 8'h03, "sum_rd3");
        cpuWrite(1'b0, 10'h000);
        checkOutput("sumclr2_ovf", 32'(ovf), 32'd0);
        checkOutput("sumclr2_coll", 32'(collAny), 32'd0);

        // Summary clear and a pop on the same edge: the set survives.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 10'd0, 1'b1, 10'h050);
        tick();
        idle();
        tick();
        checkOutput("set_wins_coll", 32'(collAny), 32'd1);
        cpuRead(1'b1, 10'h050, 8'h01, "rd_050");

        // Queued event and CPU clear to the same index: the clear goes first.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 10'h011, 1'b1, 10'h011);
        tick();
        idle();
        tick();
        tick();
        cpuRead(1'b1, 10'h011, 8'h01, "rd_011");

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'h060);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'h061);
        tick();
        checkOutput("drain_coll_pre", 32'(collAny), 32'd1);
        checkOutput("drain_dout_pre", 32'(cpuDout), 32'h01);
        idle();
        rstN = 1'b0;
        #1;
        checkResetOutputs("rst_drain");
        tick();
        rstN = 1'b1;
        for (int i = 0; i < 500; i++) tick();
        checkOutput("mid_sweep_busy", 32'(busy), 32'd1);
        rstN = 1'b0;
        #1;
        checkResetOutputs("rst_sweep");
        tick();
        rstN = 1'b1;
        runSweep("sweep1");
        cpuRead(1'b1, 10'h060, 8'h00, "rd_060");
        cpuRead(1'b1, 10'h061, 8'h00, "rd_061");
        cpuRead(1'b1, 10'h050, 8'h00, "rd_050_swept");
        cpuRead(1'b0, 10'h000, 8'h00, "sum_rd_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
